// File: rtl/uart_tx_port_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM encoding,
// register offsets and STATUS bit positions.
package uart_tx_port_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam logic [15:0] REG_STATUS = 16'd0;
  localparam logic [15:0] REG_DATA   = 16'd1;

  localparam int STATUS_READY    = 0;
  localparam int STATUS_IDLE     = 1;
  localparam int STATUS_OVERFLOW = 2;

  function automatic logic [7:0] pack_status(input logic ready, input logic idle,
                                             input logic overflow);
    logic [7:0] s;
    s = 8'h00;
    s[STATUS_READY]    = ready;
    s[STATUS_IDLE]     = idle;
    s[STATUS_OVERFLOW] = overflow;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and same-cycle push/pop.
// A push while full is ignored even if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// Bus-mapped 8N1 UART transmitter: STATUS/DATA register window, transmit
// FIFO and a bit-timed serialiser that chains queued frames back to back.
module uart_tx_port
  import uart_tx_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR    = 16'hF200,
  parameter int          CLKS_PER_BIT = 521,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        tx
);

  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  tx_state_t      state, state_next;
  logic [TW-1:0]  bit_timer, timer_next;
  logic [2:0]     bit_index, index_next;
  logic [7:0]     shift_reg, shift_next;
  logic           tx_next;
  logic           overflow;

  logic           sel_status, sel_data, wr_status, wr_data;
  logic           fifo_full, fifo_empty, fifo_pop;
  logic [7:0]     fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           bit_done;

  assign sel_status = (address == BASE_ADDR + REG_STATUS);
  assign sel_data   = (address == BASE_ADDR + REG_DATA);
  assign wr_status  = write_en && sel_status;
  assign wr_data    = write_en && sel_data;
  assign bit_done   = (bit_timer == TIMER_LAST);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) tx_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_data),
    .push_data (data_in),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    data_out = 8'h00;
    if (sel_status)
      data_out = pack_status(!fifo_full, (fifo_count == '0) && (state == ST_IDLE), overflow);
  end

  // A new frame is loaded from the FIFO both from IDLE and on the final
  // STOP cycle, so queued bytes leave with no idle gap in between.
  always_comb begin
    state_next = state;
    timer_next = bit_timer;
    index_next = bit_index;
    shift_next = shift_reg;
    tx_next    = tx;
    fifo_pop   = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_next = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shift_next = fifo_head;
          state_next = ST_START;
          tx_next    = 1'b0;
          timer_next = '0;
          index_next = '0;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_next = ST_DATA;
          timer_next = '0;
          index_next = '0;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
        end else begin
          timer_next = bit_timer + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          timer_next = '0;
          if (bit_index == 3'd7) begin
            state_next = ST_STOP;
            tx_next    = 1'b1;
          end else begin
            index_next = bit_index + 1'b1;
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
          end
        end else begin
          timer_next = bit_timer + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          timer_next = '0;
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = fifo_head;
            state_next = ST_START;
            tx_next    = 1'b0;
            index_next = '0;
          end else begin
            state_next = ST_IDLE;
            tx_next    = 1'b1;
          end
        end else begin
          timer_next = bit_timer + 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // A write dropped on a full FIFO wins over a coincident STATUS clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      bit_timer <= '0;
      bit_index <= '0;
      shift_reg <= '0;
      tx        <= 1'b1;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      bit_timer <= timer_next;
      bit_index <= index_next;
      shift_reg <= shift_next;
      tx        <= tx_next;
      if (wr_data && fifo_full)
        overflow <= 1'b1;
      else if (wr_status)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Scoreboard bench for uart_tx_port: a timing model predicts each frame's
// start edge and bit pattern; a line monitor decodes tx and checks them.
module tb_uart_tx_port;

  localparam int CPB       = 4;
  localparam int DEPTH     = 4;
  localparam int FRAME_CYC = 10 * CPB;
  localparam logic [15:0] A_STATUS = 16'hF200;
  localparam logic [15:0] A_DATA   = 16'hF201;
  localparam logic [15:0] A_BELOW  = 16'hF1FF;
  localparam logic [15:0] A_ABOVE  = 16'hF202;
  localparam logic [15:0] A_FAR    = 16'hFF00;

  logic        clock;
  logic        reset;
  logic [15:0] address;
  logic        write_en;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        tx;

  uart_tx_port #(.BASE_ADDR(A_STATUS), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    int         s;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  bit   model_ovf;
  int   edge_cnt;
  int   tests;
  int   fails;
  int   frames_done;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: a byte written at edge e starts at max(e+1, previous
  // start + frame length) and leaves the FIFO at its start edge.
  function automatic int occupancy_at(input int e);
    int n;
    n = 0;
    foreach (starts[i]) if (starts[i] >= e) n++;
    return n;
  endfunction

  task automatic model_write(input logic [7:0] b, input int e);
    int s;
    exp_t item;
    if (occupancy_at(e) >= DEPTH) begin
      model_ovf = 1'b1;
    end else begin
      s = e + 1;
      if (starts.size() > 0 && starts[starts.size()-1] + FRAME_CYC > s)
        s = starts[starts.size()-1] + FRAME_CYC;
      starts.push_back(s);
      item.b = b;
      item.s = s;
      exp_q.push_back(item);
    end
    while (starts.size() > 1 && starts[0] + FRAME_CYC < e) void'(starts.pop_front());
  endtask

  function automatic logic [7:0] model_status(input int t);
    int  pending;
    logic idle;
    pending = 0;
    foreach (starts[i]) if (starts[i] > t) pending++;
    idle = (starts.size() == 0) || (starts[starts.size()-1] + FRAME_CYC <= t);
    return {5'b0, model_ovf, idle, (pending < DEPTH)};
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a, input int t);
    return (a == A_STATUS) ? model_status(t) : 8'h00;
  endfunction

  task automatic do_cycle(input logic we, input logic [15:0] addr, input logic [7:0] din);
    int e;
    e = edge_cnt + 1;
    write_en = we;
    address  = addr;
    data_in  = din;
    if (reset) begin
      starts.delete();
      exp_q.delete();
      model_ovf = 1'b0;
    end else if (we && addr == A_DATA) begin
      model_write(din, e);
    end else if (we && addr == A_STATUS) begin
      model_ovf = 1'b0;
    end
    @(posedge clock);
    edge_cnt++;
    #1;
    write_en = 1'b0;
  endtask

  task automatic check_status(input string name);
    address = A_STATUS;
    #1;
    check_val(name, data_out, model_status(edge_cnt));
  endtask

  task automatic wait_idle(input int budget, output int idle_edge);
    int n;
    bit timed_out;
    timed_out = 1'b1;
    idle_edge = -1;
    for (n = 0; n < budget; n++) begin
      do_cycle(1'b0, A_STATUS, 8'h00);
      if (data_out[1] === 1'b1) begin
        timed_out = 1'b0;
        idle_edge = edge_cnt;
        break;
      end
    end
    check_val("idle_wait_timeout", timed_out, 1'b0);
  endtask

  // Line monitor: a low tx sample outside reset marks a start bit; the
  // whole 10-bit frame is captured cycle by cycle and checked.
  exp_t        mon_item;
  bit          mon_have;
  bit          mon_abort;
  int          mon_start;
  logic [FRAME_CYC-1:0] mon_got;
  logic [FRAME_CYC-1:0] mon_exp;
  logic [9:0]  mon_f10;

  initial begin
    forever begin
      @(negedge clock);
      if (reset !== 1'b0 || tx !== 1'b0) continue;
      mon_start = edge_cnt;
      mon_have  = (exp_q.size() > 0);
      if (mon_have) begin
        mon_item = exp_q.pop_front();
        check_val("frame_start_edge", 64'(mon_start), 64'(mon_item.s));
      end else begin
        check_val("unexpected_frame_start", 64'(mon_start), 64'hFFFF_FFFF);
      end
      mon_got    = '0;
      mon_got[0] = tx;
      mon_abort  = 1'b0;
      for (int k = 1; k < FRAME_CYC; k++) begin
        @(negedge clock);
        if (reset) begin
          mon_abort = 1'b1;
          break;
        end
        mon_got[k] = tx;
      end
      if (mon_abort || !mon_have) continue;
      mon_f10 = {1'b1, mon_item.b, 1'b0};
      for (int k = 0; k < FRAME_CYC; k++) mon_exp[k] = mon_f10[k / CPB];
      check_val("frame_bits", mon_got, mon_exp);
      frames_done++;
    end
  end

  initial begin
    int e0;
    int ie;
    int s;
    int f0;
    int r;
    logic [15:0] ra;
    logic [15:0] read_addrs [3];
    logic [7:0]  st_before;

    tests = 0; fails = 0; frames_done = 0; edge_cnt = 0; model_ovf = 1'b0;
    reset = 1'b1; write_en = 1'b0; address = 16'h0000; data_in = 8'h00;
    read_addrs[0] = A_BELOW; read_addrs[1] = A_ABOVE; read_addrs[2] = A_FAR;

    repeat (3) do_cycle(1'b0, A_STATUS, 8'h00);
    reset = 1'b0;
    do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("reset_tx", tx, 1'b1);
    check_val("reset_status", data_out, 8'h03);
    address = A_DATA;
    #1 check_val("data_reg_read", data_out, 8'h00);

    // Single frame 0xA5 with fixed latency
    do_cycle(1'b1, A_DATA, 8'hA5);
    do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("first_start_tx", tx, 1'b0);
    check_val("busy_status", data_out, 8'h01);
    wait_idle(200, ie);
    check_status("a5_done_status_model");
    check_val("a5_done_status", data_out, 8'h03);
    check_val("a5_frame_count", 64'(frames_done), 64'd1);

    // Three back-to-back frames
    e0 = edge_cnt + 1;
    do_cycle(1'b1, A_DATA, 8'h01);
    do_cycle(1'b1, A_DATA, 8'h02);
    do_cycle(1'b1, A_DATA, 8'h03);
    wait_idle(400, ie);
    check_val("three_frame_span", 64'(ie - (e0 + 1)), 64'd120);
    check_val("three_frame_count", 64'(frames_done), 64'd4);

    // Overflow on a depth-4 FIFO
    f0 = frames_done;
    for (int i = 0; i < 6; i++) do_cycle(1'b1, A_DATA, 8'($urandom_range(0, 255)));
    check_status("overflow_status_model");
    check_val("overflow_bits", data_out & 8'h05, 8'h04);
    wait_idle(600, ie);
    check_val("overflow_frame_count", 64'(frames_done - f0), 64'd5);
    do_cycle(1'b1, A_STATUS, 8'h00);
    check_status("overflow_clear_model");
    check_val("overflow_clear", data_out, 8'h03);

    // Out-of-window reads while a frame is queued
    do_cycle(1'b1, A_DATA, 8'h3C);
    address = A_STATUS;
    #1 st_before = data_out;
    for (int i = 0; i < 3; i++) begin
      address = read_addrs[i];
      #1 check_val("outside_read", data_out, 8'h00);
    end
    check_status("outside_read_status");
    check_val("outside_read_unchanged", data_out, st_before);
    wait_idle(200, ie);

    // Reset during data bit 3, with writes offered during reset
    do_cycle(1'b1, A_DATA, 8'hC3);
    s = starts[starts.size()-1];
    while (edge_cnt < s + 4 + 3 * CPB + 1) do_cycle(1'b0, A_STATUS, 8'h00);
    reset = 1'b1;
    do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("midframe_reset_tx", tx, 1'b1);
    do_cycle(1'b1, A_DATA, 8'h55);
    reset = 1'b0;
    do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("post_reset_status", data_out, 8'h03);
    f0 = frames_done;
    repeat (100) do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("post_reset_frames", 64'(frames_done - f0), 64'd0);
    check_val("post_reset_queue", 64'(exp_q.size()), 64'd0);

    // Randomised bus traffic against the model
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: do_cycle(1'b1, A_DATA, 8'($urandom_range(0, 255)));
        4:          do_cycle(1'b1, A_STATUS, 8'($urandom_range(0, 255)));
        5:          do_cycle(1'b1, A_ABOVE, 8'($urandom_range(0, 255)));
        default: begin
          case ($urandom_range(0, 4))
            0:       ra = A_STATUS;
            1:       ra = A_DATA;
            2:       ra = A_BELOW;
            3:       ra = A_ABOVE;
            default: ra = 16'($urandom_range(0, 65535));
          endcase
          do_cycle(1'b0, ra, 8'h00);
        end
      endcase
      address = (i % 2 == 0) ? A_STATUS : ra;
      #1 check_val("random_read", data_out, model_read(address, edge_cnt));
    end
    wait_idle(1000, ie);
    check_status("random_final_status");
    repeat (2) do_cycle(1'b0, A_STATUS, 8'h00);
    check_val("random_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
